// File: rtl/switch_sequencer.sv
// Programmable value table driven onto a registered output, either directly by
// a selector or by a go-triggered sequence over entries 0..L-1 with a per-step dwell.
module switch_sequencer #(
  parameter int unsigned SEL_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DWELL_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [SEL_WIDTH-1:0]   wr_sel,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   mode,
  input  logic [SEL_WIDTH-1:0]   sel_in,
  input  logic                   go,
  input  logic                   abort,
  input  logic [SEL_WIDTH:0]     seq_len,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [DATA_WIDTH-1:0]  out_value,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned ENTRIES = 2 ** SEL_WIDTH;
  localparam int unsigned STEP_W  = SEL_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  table_q [ENTRIES];
  logic [STEP_W-1:0]      step;
  logic [STEP_W-1:0]      len_q;
  logic [DWELL_WIDTH-1:0] cnt;
  logic [DWELL_WIDTH-1:0] dwell_q;

  logic [STEP_W-1:0]      len_clamped_c;
  logic [STEP_W-1:0]      next_step_c;

  // Reset contents of the table, truncated to the data width.
  function automatic logic [DATA_WIDTH-1:0] default_entry(input int idx);
    case (idx)
      0:       return DATA_WIDTH'(17);
      1:       return DATA_WIDTH'(22);
      2:       return DATA_WIDTH'(30);
      3, 4, 5, 6: return DATA_WIDTH'(72);
      default: return '0;
    endcase
  endfunction

  assign len_clamped_c = (seq_len > STEP_W'(ENTRIES)) ? STEP_W'(ENTRIES) : seq_len;
  assign next_step_c   = STEP_W'(step + STEP_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        table_q[i] <= default_entry(i);
      end
      state     <= IDLE;
      out_value <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step      <= '0;
      len_q     <= '0;
      cnt       <= '0;
      dwell_q   <= '0;
    end else begin
      if (wr_en) begin
        table_q[wr_sel] <= wr_data;
      end
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (!mode) begin
            out_value <= table_q[sel_in];
            out_valid <= 1'b1;
          end else if (go) begin
            len_q   <= len_clamped_c;
            dwell_q <= dwell;
            if (len_clamped_c == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              out_value <= table_q[0];
              out_valid <= 1'b1;
              step      <= '0;
              cnt       <= dwell;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end

        // Abort wins over both dwell countdown and step advance.
        RUN: begin
          if (abort) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_WIDTH'(1);
          end else if (next_step_c < len_q) begin
            step      <= next_step_c;
            out_value <= table_q[next_step_c[SEL_WIDTH-1:0]];
            cnt       <= dwell_q;
          end else begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed vector bench for switch_sequencer: each record is applied across one
// rising edge and the registered outputs are compared 1 time unit after it.
module tb_switch_sequencer;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_sel;
  logic [7:0] wr_data;
  logic       mode;
  logic [2:0] sel_in;
  logic       go;
  logic       abort;
  logic [3:0] seq_len;
  logic [3:0] dwell;
  logic [7:0] out_value;
  logic       out_valid;
  logic       busy;
  logic       done;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic       wen;
    logic [2:0] wsel;
    logic [7:0] wdata;
    logic       md;
    logic [2:0] sel;
    logic       g;
    logic       ab;
    logic [3:0] len;
    logic [3:0] dw;
    logic [7:0] e_value;
    logic       e_valid;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  switch_sequencer #(
    .SEL_WIDTH  (3),
    .DATA_WIDTH (8),
    .DWELL_WIDTH(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .mode     (mode),
    .sel_in   (sel_in),
    .go       (go),
    .abort    (abort),
    .seq_len  (seq_len),
    .dwell    (dwell),
    .out_value(out_value),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic rst, input logic wen, input logic [2:0] wsel,
                              input logic [7:0] wdata, input logic md, input logic [2:0] sel,
                              input logic g, input logic ab, input logic [3:0] len,
                              input logic [3:0] dw, input logic [7:0] ev, input logic evld,
                              input logic eb, input logic ed);
    vec_t t;
    t.rst = rst; t.wen = wen; t.wsel = wsel; t.wdata = wdata; t.md = md; t.sel = sel;
    t.g = g; t.ab = ab; t.len = len; t.dw = dw;
    t.e_value = ev; t.e_valid = evld; t.e_busy = eb; t.e_done = ed;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string tag, input int idx);
    reset   = t.rst;
    wr_en   = t.wen;
    wr_sel  = t.wsel;
    wr_data = t.wdata;
    mode    = t.md;
    sel_in  = t.sel;
    go      = t.g;
    abort   = t.ab;
    seq_len = t.len;
    dwell   = t.dw;
    @(posedge clock);
    #1;
    total++;
    if (out_value !== t.e_value) begin
      bad++;
      $display("FAIL %s[%0d] out_value got=%0d exp=%0d", tag, idx, out_value, t.e_value);
    end
    total++;
    if (out_valid !== t.e_valid) begin
      bad++;
      $display("FAIL %s[%0d] out_valid got=%0b exp=%0b", tag, idx, out_valid, t.e_valid);
    end
    total++;
    if (busy !== t.e_busy) begin
      bad++;
      $display("FAIL %s[%0d] busy got=%0b exp=%0b", tag, idx, busy, t.e_busy);
    end
    total++;
    if (done !== t.e_done) begin
      bad++;
      $display("FAIL %s[%0d] done got=%0b exp=%0b", tag, idx, done, t.e_done);
    end
  endtask

  vec_t vecs[$];
  vec_t seq_abort[$];
  vec_t seq_reset[$];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0; mode = 1'b0;
    sel_in = '0; go = 1'b0; abort = 1'b0; seq_len = '0; dwell = '0;

    //            rst wen ws wd  md sel g ab len dw   val vld bsy dn
    // Reset and direct mode
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  17, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0,  22, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2, 0, 0, 0, 0,  30, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 5, 0, 0, 0, 0,  72, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 7, 0, 0, 0, 0,   0, 1, 0, 0));
    // Same-cycle write returns old value, new value next cycle
    vecs.push_back(mk(0, 1, 1, 99, 0, 1, 0, 0, 0, 0,  22, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0,  99, 1, 0, 0));
    // Reset overrides a concurrent write and restores entry 1
    vecs.push_back(mk(1, 1, 2, 55, 0, 2, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2, 0, 0, 0, 0,  30, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0,  22, 1, 0, 0));
    // Sequence mode, idle hold, then L=3 D=1; go mid-run ignored
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  22, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 3, 1,  17, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  17, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 8, 0,  22, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  22, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  30, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  30, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 3, 0,  30, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  30, 1, 0, 0));
    // L=0: straight to FINISH, output untouched
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 0, 5,  30, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  30, 1, 0, 0));
    // seq_len=15 clamps to 8 steps, D=0
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 0, 15, 0, 17, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  22, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  30, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  72, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  72, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  72, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  72, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,   0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0,   0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 1, 0, 0,   0, 1, 0, 0));
    // Direct mode ignores go and abort
    vecs.push_back(mk(0, 0, 0, 0,  0, 2, 1, 1, 3, 0,  30, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2, 0, 0, 0, 0,  30, 1, 0, 0));

    // Abort during the second cycle of step 1 (D=3)
    seq_abort.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    seq_abort.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3, 3, 17, 1, 1, 0));
    seq_abort.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 17, 1, 1, 0));
    seq_abort.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 17, 1, 1, 0));
    seq_abort.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 17, 1, 1, 0));
    seq_abort.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 22, 1, 1, 0));
    seq_abort.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 22, 1, 1, 0));
    seq_abort.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 22, 1, 0, 1));
    seq_abort.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 22, 1, 0, 0));

    // Write entry 1 during step 0 (seen when step 1 loads), then reset mid-run
    seq_reset.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3, 3, 17, 1, 1, 0));
    seq_reset.push_back(mk(0, 1, 1, 99, 1, 0, 0, 0, 0, 0, 17, 1, 1, 0));
    seq_reset.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 17, 1, 1, 0));
    seq_reset.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 17, 1, 1, 0));
    seq_reset.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 99, 1, 1, 0));
    seq_reset.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 99, 1, 1, 0));
    seq_reset.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    seq_reset.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    seq_reset.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 22, 1, 0, 0));
    seq_reset.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 17, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "table", i);
    for (int i = 0; i < seq_abort.size(); i++) apply(seq_abort[i], "abort", i);
    for (int i = 0; i < seq_reset.size(); i++) apply(seq_reset[i], "midreset", i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_sequencer.md
Name: switch_sequencer

Overview:
- Parametrised successor to the fixed selector-driven register block.
- A selector indexes a programmable value table; the selected entry is registered onto `out_value`.
- Two modes:
  - Direct: the selector is applied every cycle.
  - Sequence: on a `go` pulse, the block steps through entries 0..seq_len-1, holding each for a programmable dwell.
- Used as a small pattern/level generator feeding downstream datapath registers.

Parameters:
- SEL_WIDTH, 3, selector width; ENTRIES = 2**SEL_WIDTH.
- DATA_WIDTH, 8, table entry and output width.
- DWELL_WIDTH, 4, width of the per-step dwell count.

Ports:
- clock  input  1  global clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clock.
- wr_en  input  1  table write strobe.
- wr_sel  input  SEL_WIDTH  table write index.
- wr_data  input  DATA_WIDTH  table write data.
- mode  input  1  0 = direct, 1 = sequence; sampled only in IDLE.
- sel_in  input  SEL_WIDTH  direct-mode selector.
- go  input  1  sequence start pulse.
- abort  input  1  terminate a running sequence.
- seq_len  input  SEL_WIDTH+1  steps per sequence; sampled on go.
- dwell  input  DWELL_WIDTH  extra hold cycles per step; sampled on go.
- out_value  output  DATA_WIDTH  registered selected entry.
- out_valid  output  1  out_value holds a loaded entry.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at sequence end or abort.

Behaviour:
- Reset (synchronous, overrides everything including wr_en):
  - Table defaults, each truncated to DATA_WIDTH: entry 0=17, 1=22, 2=30, 3..6=72, all others 0. Entries beyond ENTRIES-1 do not exist.
  - State = IDLE; out_value=0, out_valid=0, busy=0, done=0; step and dwell counters = 0.
- Table write:
  - wr_en writes table[wr_sel] at the clock edge, in any state.
  - A read of the same entry in the same cycle returns the OLD value; the new value is visible from the next cycle.
- FSM states: IDLE, RUN, FINISH.
- IDLE, mode=0 (direct):
  - Each cycle, out_value <= table[sel_in] and out_valid <= 1.
  - Latency: 1 cycle from sel_in to out_value.
  - go is ignored.
- IDLE, mode=1 (sequence):
  - out_value and out_valid hold their last values.
  - On go, latch L = min(seq_len, ENTRIES) and D = dwell.
  - If L=0: go to FINISH, with out_value and out_valid unchanged.
  - Otherwise: out_value <= table[0], out_valid <= 1, step <= 0, cnt <= D, go to RUN.
- RUN:
  - busy=1.
  - If cnt != 0: cnt decrements and the output holds. Each step therefore lasts D+1 cycles.
  - If cnt == 0 and step+1 < L: step increments, out_value <= table[step+1] (table value at that edge), cnt <= D.
  - If cnt == 0 and step+1 == L: go to FINISH; out_value holds the last entry.
- FINISH:
  - done=1 for exactly one cycle, busy=0; next state is IDLE.
- abort in RUN:
  - The next state is FINISH; out_value freezes at its current value.
  - abort outside RUN is ignored.
  - abort takes priority over a step advance in the same cycle.
- go while busy or in FINISH: ignored.
- mode changes during RUN or FINISH take effect only on return to IDLE.
- Table writes during RUN affect only steps loaded after the write edge; the displayed out_value is not refreshed.
- Reset mid-RUN: returns to IDLE with defaults restored; no done pulse.
- Counter arithmetic:
  - step is SEL_WIDTH+1 bits, so the comparison with L never wraps.
  - cnt is DWELL_WIDTH bits; D = 2**DWELL_WIDTH-1 is legal.

Test Plan:
- Reset, mode=0, sel_in=0,1,2,5,7 on consecutive cycles -> out_value 17,22,30,72,0, each one cycle later; out_valid=1 from the first update.
- wr_en=1, wr_sel=1, wr_data=99 with sel_in=1 in the same cycle -> out_value=22, then 99 the next cycle.
- mode=1, seq_len=3, dwell=1, go -> out_value 17,17,22,22,30,30 with busy=1, then done=1 for one cycle, then IDLE with out_value=30.
- mode=1, seq_len=0, go -> no busy; done pulse the next cycle; out_value unchanged.
- mode=1, seq_len=15 (SEL_WIDTH=3), dwell=0, go -> 8 steps (clamped to ENTRIES), values 17,22,30,72,72,72,72,0, then done.
- Abort and reset mid-run:
  - Sequence running with dwell=3, abort in cycle 2 of step 1 -> out_value frozen at 22, done the next cycle.
  - Repeat with reset instead of abort -> all outputs 0, no done pulse, table restored.
